// File: rtl/fft_delay_buffer.sv
// Complex {Re,Im} delay line of DEPTH enabled edges for R2SDF feedback paths.
// A circular RAM of DEPTH-1 entries feeds a registered read stage; the output stays zero until the line is full.
module fft_delay_buffer #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    parameter int AW    = 10
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iFlush,
    input  logic [WIDTH-1:0] iData_Re,
    input  logic [WIDTH-1:0] iData_Im,
    output logic [WIDTH-1:0] oData_Re,
    output logic [WIDTH-1:0] oData_Im,
    output logic             oValid
);

    // The RAM is rounded up to a power of two so that the index width matches exactly.
    // Entries above DEPTH-2 are never addressed.
    localparam int PW        = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    localparam int MEM_DEPTH = 2 ** PW;
    localparam int CW        = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] PRE_FULL = CW'(DEPTH - 1);

    logic [2*WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [2*WIDTH-1:0] r_rd;
    logic [AW-1:0]      r_wptr;
    logic [CW-1:0]      r_cnt;
    logic               r_valid;

    logic               w_clr;
    logic               w_adv;
    logic [PW-1:0]      w_addr;

    assign w_clr  = iRst | iFlush;
    assign w_adv  = iEn & ~w_clr;
    assign w_addr = r_wptr[PW-1:0];

    // Read-before-write on the same address gives DEPTH-1 RAM stages plus the read register.
    always_ff @(posedge iClk) begin
        if (w_adv) begin
            r_rd          <= r_mem[w_addr];
            r_mem[w_addr] <= {iData_Re, iData_Im};
        end
    end

    always_ff @(posedge iClk) begin
        if (w_clr) begin
            r_wptr  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (iEn) begin
            r_wptr  <= (r_wptr == LAST_PTR) ? '0 : r_wptr + AW'(1);
            if (r_cnt != FULL_CNT) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_valid <= (r_cnt >= PRE_FULL);
        end
    end

    // The read register is not reset, so it is masked until the line has filled.
    assign oData_Re = r_valid ? r_rd[2*WIDTH-1:WIDTH] : '0;
    assign oData_Im = r_valid ? r_rd[WIDTH-1:0]       : '0;
    assign oValid   = r_valid;

endmodule

// File: tb/tb_fft_delay_buffer.sv
// Five delay lines of different depths share one stimulus stream.
// Each line is compared against a history queue of the inputs accepted since the last clear.
module tb_fft_delay_buffer;

    localparam int W  = 37;
    localparam int ND = 5;

    function automatic int dep_of(input int i);
        case (i)
            0:       return 2;
            1:       return 4;
            2:       return 8;
            3:       return 16;
            default: return 1024;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst, flush, en;
    logic [W-1:0] d_re, d_im;
    logic [W-1:0] o_re [ND];
    logic [W-1:0] o_im [ND];
    logic         o_v  [ND];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            fft_delay_buffer #(.WIDTH(W), .DEPTH(dep_of(gi)), .AW(10)) u_dut (
                .iClk     (clk),
                .iRst     (rst),
                .iEn      (en),
                .iFlush   (flush),
                .iData_Re (d_re),
                .iData_Im (d_im),
                .oData_Re (o_re[gi]),
                .oData_Im (o_im[gi]),
                .oValid   (o_v[gi])
            );
        end
    endgenerate

    // Reference: every sample accepted since the last reset or flush.
    logic [2*W-1:0] hist [$];
    int n_cmp = 0;
    int n_err = 0;
    bit verbose = 1'b1;

    function automatic logic exp_v(input int d);
        return hist.size() >= dep_of(d);
    endfunction

    function automatic logic [2*W-1:0] exp_data(input int d);
        if (hist.size() < dep_of(d)) return '0;
        return hist[hist.size() - dep_of(d)];
    endfunction

    function automatic logic [W-1:0] rand37();
        logic [W-1:0] v;
        v = {5'($urandom), 32'($urandom)};
        case ($urandom_range(0, 15))
            0:       v = 37'h1FFFFFFFFF;
            1:       v = 37'h1000000000;
            2:       v = '0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic tick(input logic r, input logic f, input logic e,
                        input logic [W-1:0] re, input logic [W-1:0] im);
        rst = r; flush = f; en = e; d_re = re; d_im = im;
        @(posedge clk);
        #1;
        if (r || f) hist.delete();
        else if (e) hist.push_back({re, im});
        if (verbose)
            $display("t=%0t rst=%0b flush=%0b en=%0b in=%h/%h filled=%0d d8=%h/%h v8=%0b",
                     $time, r, f, e, re, im, hist.size(), o_re[2], o_im[2], o_v[2]);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) tick(1, 0, 1, rand37(), rand37());
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (o_v[d] !== 1'b0) begin
                n_err++; $display("FAIL reset_valid D=%0d got %0b expected 0", dep_of(d), o_v[d]);
            end
            n_cmp++;
            if ({o_re[d], o_im[d]} !== '0) begin
                n_err++; $display("FAIL reset_data D=%0d got %h/%h expected 0/0", dep_of(d), o_re[d], o_im[d]);
            end
        end
    endtask

    task automatic test_depth2_legacy();
        tick(1, 0, 0, '0, '0);
        for (int k = 1; k <= 6; k++) begin
            tick(0, 0, 1, W'(k), W'(-k));
            n_cmp++;
            if (o_v[0] !== (k >= 2)) begin
                n_err++; $display("FAIL d2_valid edge=%0d got %0b expected %0b", k, o_v[0], k >= 2);
            end
            n_cmp++;
            if (k >= 2 && (o_re[0] !== W'(k - 1) || o_im[0] !== W'(-(k - 1)))) begin
                n_err++; $display("FAIL d2_data edge=%0d got %h/%h expected %h/%h",
                                  k, o_re[0], o_im[0], W'(k - 1), W'(-(k - 1)));
            end
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (o_v[d] !== exp_v(d) || {o_re[d], o_im[d]} !== exp_data(d)) begin
                    n_err++; $display("FAIL d2_model D=%0d got %0b %h/%h expected %0b %h",
                                      dep_of(d), o_v[d], o_re[d], o_im[d], exp_v(d), exp_data(d));
                end
            end
        end
    endtask

    task automatic test_depth8_ramp();
        tick(1, 0, 0, '0, '0);
        for (int n = 1; n <= 40; n++) begin
            tick(0, 0, 1, W'(n), ~W'(n));
            n_cmp++;
            if (o_v[2] !== (n >= 8) || o_re[2] !== ((n >= 8) ? W'(n - 7) : '0)) begin
                n_err++; $display("FAIL d8_ramp edge=%0d got %0b %0d expected %0b %0d",
                                  n, o_v[2], o_re[2], n >= 8, (n >= 8) ? n - 7 : 0);
            end
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (o_v[d] !== exp_v(d) || {o_re[d], o_im[d]} !== exp_data(d)) begin
                    n_err++; $display("FAIL ramp_model D=%0d got %0b %h/%h expected %0b %h",
                                      dep_of(d), o_v[d], o_re[d], o_im[d], exp_v(d), exp_data(d));
                end
            end
        end
    endtask

    task automatic test_gated_enable();
        int m;
        logic e;
        m = 0;
        tick(1, 0, 0, '0, '0);
        for (int c = 0; c < 60; c++) begin
            e = (c % 6 == 0) || (c % 6 == 3) || (c % 6 == 4);
            if (e) m++;
            tick(0, 0, e, e ? W'(m) : W'(12345), e ? ~W'(m) : '0);
            n_cmp++;
            if (o_v[2] !== (m >= 8) || o_re[2] !== ((m >= 8) ? W'(m - 7) : '0)
                || o_im[2] !== ((m >= 8) ? ~W'(m - 7) : '0)) begin
                n_err++; $display("FAIL gated_d8 cycle=%0d en_edges=%0d got %0b %0d expected %0b %0d",
                                  c, m, o_v[2], o_re[2], m >= 8, (m >= 8) ? m - 7 : 0);
            end
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (o_v[d] !== exp_v(d) || {o_re[d], o_im[d]} !== exp_data(d)) begin
                    n_err++; $display("FAIL gated_model D=%0d got %0b %h/%h expected %0b %h",
                                      dep_of(d), o_v[d], o_re[d], o_im[d], exp_v(d), exp_data(d));
                end
            end
        end
    endtask

    task automatic test_flush();
        tick(1, 0, 0, '0, '0);
        for (int n = 1; n <= 10; n++) tick(0, 0, 1, W'(n), W'(n));
        tick(0, 1, 1, W'(99), W'(99));
        n_cmp++;
        if (o_v[1] !== 1'b0 || o_re[1] !== '0 || o_im[1] !== '0) begin
            n_err++; $display("FAIL flush_clear got %0b %h/%h expected 0 0/0", o_v[1], o_re[1], o_im[1]);
        end
        for (int j = 1; j <= 10; j++) begin
            tick(0, 0, 1, W'(199 + j), W'(199 + j));
            n_cmp++;
            if (o_v[1] !== (j >= 4) || o_re[1] !== ((j >= 4) ? W'(196 + j) : '0)) begin
                n_err++; $display("FAIL flush_refill edge=%0d got %0b %0d expected %0b %0d",
                                  j, o_v[1], o_re[1], j >= 4, (j >= 4) ? 196 + j : 0);
            end
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (o_v[d] !== exp_v(d) || {o_re[d], o_im[d]} !== exp_data(d)) begin
                    n_err++; $display("FAIL flush_model D=%0d got %0b %h/%h expected %0b %h",
                                      dep_of(d), o_v[d], o_re[d], o_im[d], exp_v(d), exp_data(d));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int n = 0; n < 30; n++) tick(0, 0, 1, rand37(), rand37());
        tick(1, 0, 1, rand37(), rand37());
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (o_v[d] !== 1'b0 || {o_re[d], o_im[d]} !== '0) begin
                n_err++; $display("FAIL midreset D=%0d got %0b %h/%h expected 0 0/0",
                                  dep_of(d), o_v[d], o_re[d], o_im[d]);
            end
        end
        for (int j = 1; j <= 20; j++) begin
            tick(0, 0, 1, rand37(), rand37());
            n_cmp++;
            if (o_v[3] !== (j >= 16)) begin
                n_err++; $display("FAIL refill_d16 edge=%0d got %0b expected %0b", j, o_v[3], j >= 16);
            end
        end
        tick(1, 1, 1, rand37(), rand37());
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (o_v[d] !== 1'b0 || {o_re[d], o_im[d]} !== '0) begin
                n_err++; $display("FAIL rst_flush_en D=%0d got %0b %h/%h expected 0 0/0",
                                  dep_of(d), o_v[d], o_re[d], o_im[d]);
            end
        end
        for (int j = 0; j < 20; j++) begin
            tick(0, 0, 1, rand37(), rand37());
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (o_v[d] !== exp_v(d) || {o_re[d], o_im[d]} !== exp_data(d)) begin
                    n_err++; $display("FAIL post_reset D=%0d got %0b %h/%h expected %0b %h",
                                      dep_of(d), o_v[d], o_re[d], o_im[d], exp_v(d), exp_data(d));
                end
            end
        end
    endtask

    task automatic test_random();
        int enabled;
        logic e;
        enabled = 0;
        verbose = 1'b0;
        tick(1, 0, 0, '0, '0);
        while (enabled < 5000) begin
            e = 1'($urandom_range(0, 1));
            if (e) enabled++;
            tick(0, 0, e, rand37(), rand37());
            for (int d = 0; d < ND; d++) begin
                n_cmp++;
                if (o_v[d] !== exp_v(d) || {o_re[d], o_im[d]} !== exp_data(d)) begin
                    n_err++; $display("FAIL random D=%0d en_edges=%0d got %0b %h/%h expected %0b %h",
                                      dep_of(d), enabled, o_v[d], o_re[d], o_im[d], exp_v(d), exp_data(d));
                end
            end
        end
        verbose = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; en = 1'b0; d_re = '0; d_im = '0;
        test_reset();
        test_depth2_legacy();
        test_depth8_ramp();
        test_gated_enable();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
